// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: line-oriented ASCII command controller sitting between a UART RX/TX pair.
//   Receives characters into a line buffer, parses LED commands (ONh / OFh / TGh) and STATUS,
//   drives per-channel outputs and sends a response frame through the UART transmitter.
// Ports:
//   i_Clock, i_Rst      clock, synchronous active-high reset
//   i_RX_DV, i_RX_Byte  received byte strobe and data
//   i_TX_Active         transmitter busy
//   i_TX_Done           end-of-byte strobe from transmitter
//   i_Sensor            NUM_CH sensor bytes, channel k at [8k+7:8k]
//   o_TX_DV, o_TX_Byte  one-cycle transmit request and its byte (held until next request)
//   o_Ch                channel (LED) outputs
//   o_Busy              response frame in progress
//   o_Drop_Cnt          saturating count of responses dropped while busy
module uart_cmd_ctrl #(
   parameter int NUM_CH  = 4,
   parameter int BUF_LEN = 8
) (
   input  logic                  i_Clock,
   input  logic                  i_Rst,
   input  logic                  i_RX_DV,
   input  logic [7:0]            i_RX_Byte,
   input  logic                  i_TX_Active,
   input  logic                  i_TX_Done,
   input  logic [8*NUM_CH-1:0]   i_Sensor,
   output logic                  o_TX_DV,
   output logic [7:0]            o_TX_Byte,
   output logic [NUM_CH-1:0]     o_Ch,
   output logic                  o_Busy,
   output logic [7:0]            o_Drop_Cnt
);

   localparam logic [1:0] RESP_OK   = 2'd0;
   localparam logic [1:0] RESP_ERR  = 2'd1;
   localparam logic [1:0] RESP_STAT = 2'd2;

   typedef enum logic [1:0] {StIdle, StSend, StWait} tx_state_t;

   logic [7:0]          r_Buf [BUF_LEN];
   logic [4:0]          r_Cnt;
   logic                r_Ovf;
   logic [NUM_CH-1:0]   r_Ch;
   logic [8*NUM_CH-1:0] r_Sens;
   logic [1:0]          r_Resp;
   logic [4:0]          r_Idx;
   logic                r_TX_DV;
   logic [7:0]          r_TX_Byte;
   logic [7:0]          r_Drop_Cnt;
   tx_state_t           r_State;
   tx_state_t           w_State_Next;

   logic                w_LF;
   logic                w_Hex_Ok;
   logic [3:0]          w_Hex_Val;
   logic                w_Is_On;
   logic                w_Is_Of;
   logic                w_Is_Tg;
   logic                w_Led_Ok;
   logic                w_Status;
   logic                w_Accept;
   logic                w_Last;
   logic                w_Fire;
   logic [7:0]          w_Byte;
   logic [7:0]          w_Cksum;

   assign w_LF = i_RX_DV && (i_RX_Byte == 8'h0A);

   // ---------------------------------------------------------------- receive buffer
   always_ff @(posedge i_Clock) begin
      if (i_Rst) begin
         r_Cnt <= 5'd0;
         r_Ovf <= 1'b0;
         for (int k = 0; k < BUF_LEN; k++) r_Buf[k] <= 8'h00;
      end else if (i_RX_DV) begin
         if (i_RX_Byte == 8'h0A) begin
            r_Cnt <= 5'd0;
            r_Ovf <= 1'b0;
            for (int k = 0; k < BUF_LEN; k++) r_Buf[k] <= 8'h00;
         end else if (i_RX_Byte != 8'h0D) begin
            if (int'(r_Cnt) < BUF_LEN) begin
               for (int k = 0; k < BUF_LEN; k++) begin
                  if (int'(r_Cnt) == k) r_Buf[k] <= i_RX_Byte;
               end
               r_Cnt <= r_Cnt + 5'd1;
            end else begin
               // Buffer full: keep contents, remember the line is bad
               r_Ovf <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------- command decode
   always_comb begin
      w_Hex_Ok  = 1'b0;
      w_Hex_Val = 4'd0;
      if (r_Buf[2] >= 8'h30 && r_Buf[2] <= 8'h39) begin
         w_Hex_Ok  = 1'b1;
         w_Hex_Val = r_Buf[2][3:0];
      end else if (r_Buf[2] >= 8'h41 && r_Buf[2] <= 8'h46) begin
         w_Hex_Ok  = 1'b1;
         w_Hex_Val = r_Buf[2][3:0] + 4'd9;  // 'A' = 0x41 -> 10
      end
   end

   assign w_Is_On  = (r_Buf[0] == 8'h4F) && (r_Buf[1] == 8'h4E);
   assign w_Is_Of  = (r_Buf[0] == 8'h4F) && (r_Buf[1] == 8'h46);
   assign w_Is_Tg  = (r_Buf[0] == 8'h54) && (r_Buf[1] == 8'h47);
   assign w_Led_Ok = (r_Cnt == 5'd3) && !r_Ovf && w_Hex_Ok && (int'(w_Hex_Val) < NUM_CH)
                     && (w_Is_On || w_Is_Of || w_Is_Tg);
   assign w_Status = (r_Cnt == 5'd6) && !r_Ovf
                     && (r_Buf[0] == 8'h53) && (r_Buf[1] == 8'h54) && (r_Buf[2] == 8'h41)
                     && (r_Buf[3] == 8'h54) && (r_Buf[4] == 8'h55) && (r_Buf[5] == 8'h53);

   // A response is only started from IDLE; otherwise it is dropped and counted
   assign w_Accept = w_LF && (r_State == StIdle);

   // ---------------------------------------------------------------- channel outputs
   always_ff @(posedge i_Clock) begin
      if (i_Rst) begin
         r_Ch <= '0;
      end else if (w_LF && w_Led_Ok) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (int'(w_Hex_Val) == k) begin
               if (w_Is_On)      r_Ch[k] <= 1'b1;
               else if (w_Is_Of) r_Ch[k] <= 1'b0;
               else              r_Ch[k] <= ~r_Ch[k];
            end
         end
      end
   end

   // ---------------------------------------------------------------- response bookkeeping
   always_ff @(posedge i_Clock) begin
      if (i_Rst) begin
         r_Resp     <= RESP_ERR;
         r_Sens     <= '0;
         r_Drop_Cnt <= 8'h00;
      end else begin
         if (w_Accept) begin
            if (w_Led_Ok)      r_Resp <= RESP_OK;
            else if (w_Status) r_Resp <= RESP_STAT;
            else               r_Resp <= RESP_ERR;
            if (w_Status) r_Sens <= i_Sensor;
         end
         if (w_LF && (r_State != StIdle) && (r_Drop_Cnt != 8'hFF)) begin
            r_Drop_Cnt <= r_Drop_Cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Rst) begin
         r_Idx <= 5'd0;
      end else if (w_Accept) begin
         r_Idx <= 5'd0;
      end else if ((r_State == StWait) && i_TX_Done && !w_Last) begin
         r_Idx <= r_Idx + 5'd1;
      end
   end

   always_comb begin
      w_Cksum = 8'h00;
      for (int k = 0; k < NUM_CH; k++) w_Cksum = w_Cksum ^ r_Sens[8*k +: 8];
   end

   assign w_Last = (r_Resp == RESP_STAT) ? (int'(r_Idx) == NUM_CH + 2) : (r_Idx == 5'd1);

   // ---------------------------------------------------------------- TX FSM: state register
   always_ff @(posedge i_Clock) begin
      if (i_Rst) r_State <= StIdle;
      else       r_State <= w_State_Next;
   end

   // ---------------------------------------------------------------- TX FSM: next state
   always_comb begin
      w_State_Next = r_State;
      unique case (r_State)
         StIdle: if (w_Accept) w_State_Next = StSend;
         StSend: if (!i_TX_Active) w_State_Next = StWait;
         StWait: if (i_TX_Done) w_State_Next = w_Last ? StIdle : StSend;
         default: w_State_Next = StIdle;
      endcase
   end

   // ---------------------------------------------------------------- TX FSM: outputs
   always_comb begin
      w_Fire = (r_State == StSend) && !i_TX_Active;
      w_Byte = 8'h0A;
      case (r_Resp)
         RESP_OK: begin
            if (r_Idx == 5'd0) w_Byte = 8'h4B;
         end
         RESP_STAT: begin
            if (r_Idx == 5'd0) begin
               w_Byte = 8'h3E;
            end else if (int'(r_Idx) == NUM_CH + 1) begin
               w_Byte = w_Cksum;
            end else begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (int'(r_Idx) == k + 1) w_Byte = r_Sens[8*k +: 8];
               end
            end
         end
         default: begin
            if (r_Idx == 5'd0) w_Byte = 8'h3F;
         end
      endcase
   end

   // Registered request: o_TX_DV pulses on the cycle after SEND sees the transmitter free
   always_ff @(posedge i_Clock) begin
      if (i_Rst) begin
         r_TX_DV   <= 1'b0;
         r_TX_Byte <= 8'h00;
      end else begin
         r_TX_DV <= w_Fire;
         if (w_Fire) r_TX_Byte <= w_Byte;
      end
   end

   assign o_TX_DV    = r_TX_DV;
   assign o_TX_Byte  = r_TX_Byte;
   assign o_Ch       = r_Ch;
   assign o_Busy     = (r_State != StIdle);
   assign o_Drop_Cnt = r_Drop_Cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl (NUM_CH=4, BUF_LEN=8).
//   A simple transmitter model captures every o_TX_DV byte into a queue and answers with
//   i_TX_Active for a few cycles followed by an i_TX_Done strobe.
module tb_uart_cmd_ctrl;

   localparam int NUM_CH  = 4;
   localparam int BUF_LEN = 8;

   logic                i_Clock = 1'b0;
   logic                i_Rst;
   logic                i_RX_DV;
   logic [7:0]          i_RX_Byte;
   logic                i_TX_Active;
   logic                i_TX_Done;
   logic [8*NUM_CH-1:0] i_Sensor;
   logic                o_TX_DV;
   logic [7:0]          o_TX_Byte;
   logic [NUM_CH-1:0]   o_Ch;
   logic                o_Busy;
   logic [7:0]          o_Drop_Cnt;

   int checks = 0;
   int errors = 0;
   logic [7:0] q[$];

   always #5 i_Clock = ~i_Clock;

   uart_cmd_ctrl #(
      .NUM_CH  (NUM_CH),
      .BUF_LEN (BUF_LEN)
   ) dut (
      .i_Clock     (i_Clock),
      .i_Rst       (i_Rst),
      .i_RX_DV     (i_RX_DV),
      .i_RX_Byte   (i_RX_Byte),
      .i_TX_Active (i_TX_Active),
      .i_TX_Done   (i_TX_Done),
      .i_Sensor    (i_Sensor),
      .o_TX_DV     (o_TX_DV),
      .o_TX_Byte   (o_TX_Byte),
      .o_Ch        (o_Ch),
      .o_Busy      (o_Busy),
      .o_Drop_Cnt  (o_Drop_Cnt)
   );

   // Transmitter model
   initial begin
      i_TX_Active = 1'b0;
      i_TX_Done   = 1'b0;
      forever begin
         @(negedge i_Clock);
         if (o_TX_DV === 1'b1) begin
            q.push_back(o_TX_Byte);
            i_TX_Active = 1'b1;
            repeat (3) @(negedge i_Clock);
            i_TX_Active = 1'b0;
            i_TX_Done   = 1'b1;
            @(negedge i_Clock);
            i_TX_Done   = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      i_RX_Byte = b;
      i_RX_DV   = 1'b1;
      @(negedge i_Clock);
      i_RX_DV   = 1'b0;
      i_RX_Byte = 8'h00;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic send_line(input string s);
      send_str(s);
      send_byte(8'h0A);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((o_Busy || i_TX_Active || i_TX_Done) && n < 1000) begin
         @(negedge i_Clock);
         n++;
      end
      repeat (2) @(negedge i_Clock);
      checks++;
      if (n >= 1000) begin
         errors++;
         $display("FAIL %s: timeout waiting for idle, busy=%b required 0", name, o_Busy);
      end
   endtask

   task automatic test_reset();
      i_Rst     = 1'b1;
      i_RX_DV   = 1'b1;      // LF strobe held during reset must be ignored
      i_RX_Byte = 8'h0A;
      repeat (2) @(negedge i_Clock);
      checks += 5;
      if (o_Ch !== 4'b0000) begin errors++; $display("FAIL reset_ch: got %b required 0000", o_Ch); end
      if (o_TX_DV !== 1'b0) begin errors++; $display("FAIL reset_txdv: got %b required 0", o_TX_DV); end
      if (o_TX_Byte !== 8'h00) begin errors++; $display("FAIL reset_txbyte: got %h required 00", o_TX_Byte); end
      if (o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", o_Busy); end
      if (o_Drop_Cnt !== 8'h00) begin errors++; $display("FAIL reset_drop: got %h required 00", o_Drop_Cnt); end
      i_Rst     = 1'b0;
      i_RX_DV   = 1'b0;
      i_RX_Byte = 8'h00;
      repeat (4) @(negedge i_Clock);
      checks += 2;
      if (o_Busy !== 1'b0) begin errors++; $display("FAIL reset_rxdv_ignored: busy got %b required 0", o_Busy); end
      if (q.size() != 0) begin errors++; $display("FAIL reset_no_tx: got %0d bytes required 0", q.size()); end
   endtask

   task automatic test_led();
      logic [7:0] exp[$];
      bit ok;
      exp = '{8'h4B, 8'h0A};
      q.delete();
      send_line("ON2");
      wait_idle("on2");
      ok = (q.size() == exp.size());
      for (int i = 0; i < exp.size() && ok; i++) if (q[i] !== exp[i]) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL led_on2_reply: got %p required %p", q, exp); end
      checks++;
      if (o_Ch !== 4'b0100) begin errors++; $display("FAIL led_on2_ch: got %b required 0100", o_Ch); end
      q.delete();
      send_line("TG0");
      wait_idle("tg0");
      ok = (q.size() == exp.size());
      for (int i = 0; i < exp.size() && ok; i++) if (q[i] !== exp[i]) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL led_tg0_reply: got %p required %p", q, exp); end
      checks++;
      if (o_Ch !== 4'b0101) begin errors++; $display("FAIL led_tg0_ch: got %b required 0101", o_Ch); end
   endtask

   task automatic test_status();
      logic [7:0] exp[$];
      bit ok;
      exp = '{8'h3E, 8'h7B, 8'hCD, 8'h01, 8'h10, 8'hA7, 8'h0A};
      q.delete();
      send_line("STATUS");
      wait_idle("status");
      ok = (q.size() == exp.size());
      for (int i = 0; i < exp.size() && ok; i++) if (q[i] !== exp[i]) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL status_frame: got %p required %p", q, exp); end
      checks++;
      if (o_Ch !== 4'b0101) begin errors++; $display("FAIL status_ch: got %b required 0101", o_Ch); end
   endtask

   task automatic test_errors();
      string cmds[4];
      logic [7:0] exp[$];
      bit ok;
      cmds = '{"ON4", "on1", "XYZ", ""};
      exp  = '{8'h3F, 8'h0A};
      for (int c = 0; c < 4; c++) begin
         q.delete();
         send_line(cmds[c]);
         wait_idle("err");
         ok = (q.size() == exp.size());
         for (int i = 0; i < exp.size() && ok; i++) if (q[i] !== exp[i]) ok = 0;
         checks++;
         if (!ok) begin errors++; $display("FAIL err_reply[%0d]: got %p required %p", c, q, exp); end
         checks++;
         if (o_Ch !== 4'b0101) begin
            errors++; $display("FAIL err_ch[%0d]: got %b required 0101", c, o_Ch);
         end
      end
   endtask

   task automatic test_latency();
      int n = 0;
      q.delete();
      send_line("ON3");
      checks++;
      if (o_Ch !== 4'b1101) begin errors++; $display("FAIL lat_ch_next_edge: got %b required 1101", o_Ch); end
      while (o_TX_DV !== 1'b1 && n < 5) begin
         @(negedge i_Clock);
         n++;
      end
      checks++;
      if (n < 1 || n > 2) begin errors++; $display("FAIL latency: got %0d cycles required 1..2", n); end
      wait_idle("latency");
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp[$];
      bit ok;
      exp = '{8'h3E, 8'h7B, 8'hCD, 8'h01, 8'h10, 8'hA7, 8'h0A};
      q.delete();
      send_str("STATUS");
      send_byte(8'h0D);
      send_byte(8'h0A);
      send_line("OF0");
      checks++;
      if (o_Ch !== 4'b1100) begin errors++; $display("FAIL b2b_ch_while_busy: got %b required 1100", o_Ch); end
      wait_idle("b2b");
      ok = (q.size() == exp.size());
      for (int i = 0; i < exp.size() && ok; i++) if (q[i] !== exp[i]) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_frame: got %p required %p", q, exp); end
      checks++;
      if (o_Drop_Cnt !== 8'd1) begin errors++; $display("FAIL b2b_drop: got %0d required 1", o_Drop_Cnt); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp[$];
      bit ok;
      exp = '{8'h3F, 8'h0A};
      q.delete();
      send_line("ABCDEFGHIJKL");
      wait_idle("ovf");
      ok = (q.size() == exp.size());
      for (int i = 0; i < exp.size() && ok; i++) if (q[i] !== exp[i]) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_reply: got %p required %p", q, exp); end
      exp = '{8'h4B, 8'h0A};
      q.delete();
      send_line("ON1");
      wait_idle("ovf_on1");
      ok = (q.size() == exp.size());
      for (int i = 0; i < exp.size() && ok; i++) if (q[i] !== exp[i]) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_next_reply: got %p required %p", q, exp); end
      checks++;
      if (o_Ch !== 4'b1110) begin errors++; $display("FAIL ovf_next_ch: got %b required 1110", o_Ch); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp[$];
      bit ok;
      int n = 0;
      int dv = 0;
      q.delete();
      send_line("STATUS");
      while (q.size() < 3 && n < 200) begin
         @(negedge i_Clock);
         n++;
      end
      checks++;
      if (n >= 200) begin errors++; $display("FAIL rstmid_wait: got %0d bytes required 3", q.size()); end
      i_Rst = 1'b1;
      @(negedge i_Clock);
      checks += 5;
      if (o_Ch !== 4'b0000) begin errors++; $display("FAIL rstmid_ch: got %b required 0000", o_Ch); end
      if (o_TX_DV !== 1'b0) begin errors++; $display("FAIL rstmid_txdv: got %b required 0", o_TX_DV); end
      if (o_TX_Byte !== 8'h00) begin errors++; $display("FAIL rstmid_txbyte: got %h required 00", o_TX_Byte); end
      if (o_Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", o_Busy); end
      if (o_Drop_Cnt !== 8'h00) begin errors++; $display("FAIL rstmid_drop: got %h required 00", o_Drop_Cnt); end
      i_Rst = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge i_Clock);
         if (o_TX_DV === 1'b1) dv++;
      end
      checks += 2;
      if (dv != 0) begin errors++; $display("FAIL rstmid_no_txdv: got %0d pulses required 0", dv); end
      if (q.size() != 3) begin errors++; $display("FAIL rstmid_bytes: got %0d required 3", q.size()); end
      exp = '{8'h4B, 8'h0A};
      q.delete();
      send_line("ON0");
      wait_idle("rstmid_on0");
      ok = (q.size() == exp.size());
      for (int i = 0; i < exp.size() && ok; i++) if (q[i] !== exp[i]) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_new_reply: got %p required %p", q, exp); end
      checks++;
      if (o_Ch !== 4'b0001) begin errors++; $display("FAIL rstmid_new_ch: got %b required 0001", o_Ch); end
   endtask

   initial begin
      i_Rst     = 1'b1;
      i_RX_DV   = 1'b0;
      i_RX_Byte = 8'h00;
      i_Sensor  = {8'h10, 8'h01, 8'hCD, 8'h7B};
      test_reset();
      test_led();
      test_status();
      test_errors();
      test_latency();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
